// File: rtl/ysyx_24080006_rvc_pack.sv
// Streaming RVC compressor and packer: compresses RV32 instructions to their
// 16-bit C forms where possible and packs the mixed stream little-endian into
// 32-bit words (lower half is earlier in program order).
module ysyx_24080006_rvc_pack #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             idle,
  output logic             err,
  output logic [CNT_W-1:0] stat_total,
  output logic [CNT_W-1:0] stat_comp
);

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic        imm_small, sp_off_ok, sp_soff_ok, lw_off_ok;
  logic        is_addi, is_add, is_lw, is_sw, is_jalr;
  logic        c_ok;
  logic [15:0] c16;

  logic [15:0]      hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [31:0]      out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stat_total_q, stat_total_d;
  logic [CNT_W-1:0] stat_comp_q, stat_comp_d;

  logic slot_free, accept, flush_fire;

  assign opc   = in_inst[6:0];
  assign rd    = in_inst[11:7];
  assign f3    = in_inst[14:12];
  assign rs1   = in_inst[19:15];
  assign rs2   = in_inst[24:20];
  assign f7    = in_inst[31:25];
  assign imm_i = in_inst[31:20];
  assign imm_s = {in_inst[31:25], in_inst[11:7]};

  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_add  = (opc == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0);
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_jalr = (opc == 7'b1100111) && (f3 == 3'b000);

  // Sign-extended 6-bit range [-32,31]: bits 11..5 all equal
  assign imm_small  = (imm_i[11:5] == '0) || (imm_i[11:5] == '1);
  // Word-aligned, non-negative, below 256 (max 252) / below 128 (max 124)
  assign sp_off_ok  = (imm_i[11:8] == '0) && (imm_i[1:0] == '0);
  assign sp_soff_ok = (imm_s[11:8] == '0) && (imm_s[1:0] == '0);
  assign lw_off_ok  = (imm_i[11:7] == '0) && (imm_i[1:0] == '0);

  // Compress function, first match wins
  always_comb begin
    c_ok = 1'b0;
    c16  = '0;
    if (in_inst == 32'h0000_0013) begin
      c_ok = 1'b1; c16 = 16'h0001;
    end else if (is_addi && rd == rs1 && rd != '0 && imm_i != '0 && imm_small) begin
      c_ok = 1'b1; c16 = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_addi && rs1 == '0 && rd != '0 && imm_small) begin
      c_ok = 1'b1; c16 = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
    end else if (is_add && rs1 == '0 && rd != '0 && rs2 != '0) begin
      c_ok = 1'b1; c16 = {4'b1000, rd, rs2, 2'b10};
    end else if (is_add && rs1 == rd && rd != '0 && rs2 != '0) begin
      c_ok = 1'b1; c16 = {4'b1001, rd, rs2, 2'b10};
    end else if (is_lw && rs1 == 5'd2 && rd != '0 && sp_off_ok) begin
      c_ok = 1'b1; c16 = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
    end else if (is_sw && rs1 == 5'd2 && sp_soff_ok) begin
      c_ok = 1'b1; c16 = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
    end else if (is_lw && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 && lw_off_ok) begin
      c_ok = 1'b1; c16 = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
    end else if (is_jalr && rd == '0 && imm_i == '0 && rs1 != '0) begin
      c_ok = 1'b1; c16 = {4'b1000, rs1, 5'b0, 2'b10};
    end else if (in_inst == 32'h0010_0073) begin
      c_ok = 1'b1; c16 = 16'h9002;
    end
  end

  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = slot_free && !flush;
  assign accept     = in_valid && in_ready;
  assign flush_fire = flush && slot_free && hold_v_q;

  // Packing datapath and statistics next-state
  always_comb begin
    hold_d       = hold_q;
    hold_v_d     = hold_v_q;
    out_word_d   = out_word_q;
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    stat_total_d = stat_total_q;
    stat_comp_d  = stat_comp_q;
    if (slot_free) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      stat_total_d = stat_total_q + CNT_W'(1);
      if (c_ok) begin
        stat_comp_d = stat_comp_q + CNT_W'(1);
      end
      if (in_inst[1:0] != 2'b11) begin
        err_d = 1'b1;
      end
      if (!hold_v_q) begin
        if (c_ok) begin
          hold_d   = c16;
          hold_v_d = 1'b1;
        end else begin
          out_word_d  = in_inst;
          out_valid_d = 1'b1;
        end
      end else begin
        // A pending half always completes a word; a 32-bit input leaves its
        // upper half behind, so hold_v stays set in that case.
        out_valid_d = 1'b1;
        if (c_ok) begin
          out_word_d = {c16, hold_q};
          hold_v_d   = 1'b0;
        end else begin
          out_word_d = {in_inst[15:0], hold_q};
          hold_d     = in_inst[31:16];
        end
      end
    end else if (flush_fire) begin
      out_word_d  = {16'h0001, hold_q};
      out_valid_d = 1'b1;
      hold_v_d    = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_v_q     <= 1'b0;
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      stat_total_q <= '0;
      stat_comp_q  <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_v_q     <= hold_v_d;
      out_word_q   <= out_word_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      stat_total_q <= stat_total_d;
      stat_comp_q  <= stat_comp_d;
    end
  end

  assign out_word   = out_word_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign stat_total = stat_total_q;
  assign stat_comp  = stat_comp_q;
  assign idle       = !hold_v_q && !out_valid_q;

endmodule

// File: tb/tb_ysyx_24080006_rvc_pack.sv
// Bench for the RVC compressor/packer: halfword-stream reference model checked
// every cycle, directed scenarios with literal words, and random traffic.
module tb_ysyx_24080006_rvc_pack;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, idle, err;
  logic [31:0] in_inst, out_word, stat_total, stat_comp;

  int checks = 0;
  int failures = 0;

  ysyx_24080006_rvc_pack #(.CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .idle(idle), .err(err), .stat_total(stat_total), .stat_comp(stat_comp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference compress: integer field arithmetic from the instruction rules
  function automatic logic [16:0] ref_c(input logic [31:0] x);
    int op, f3, rd, rs1, rs2, f7, im, so;
    logic [11:0] u, s;
    op = x[6:0]; f3 = x[14:12]; rd = x[11:7]; rs1 = x[19:15];
    rs2 = x[24:20]; f7 = x[31:25];
    im = $signed(x[31:20]);
    so = $signed({x[31:25], x[11:7]});
    u = x[31:20];
    s = {x[31:25], x[11:7]};
    if (x == 32'h13) return {1'b1, 16'h0001};
    if (op == 19 && f3 == 0 && rd == rs1 && rd != 0 && im != 0 && im >= -32 && im <= 31)
      return {1'b1, 3'b000, u[5], x[11:7], u[4:0], 2'b01};
    if (op == 19 && f3 == 0 && rs1 == 0 && rd != 0 && im >= -32 && im <= 31)
      return {1'b1, 3'b010, u[5], x[11:7], u[4:0], 2'b01};
    if (op == 51 && f3 == 0 && f7 == 0 && rs1 == 0 && rd != 0 && rs2 != 0)
      return {1'b1, 4'b1000, x[11:7], x[24:20], 2'b10};
    if (op == 51 && f3 == 0 && f7 == 0 && rs1 == rd && rd != 0 && rs2 != 0)
      return {1'b1, 4'b1001, x[11:7], x[24:20], 2'b10};
    if (op == 3 && f3 == 2 && rs1 == 2 && rd != 0 && im % 4 == 0 && im >= 0 && im <= 252)
      return {1'b1, 3'b010, u[5], x[11:7], u[4:2], u[7:6], 2'b10};
    if (op == 35 && f3 == 2 && rs1 == 2 && so % 4 == 0 && so >= 0 && so <= 252)
      return {1'b1, 3'b110, s[5:2], s[7:6], x[24:20], 2'b10};
    if (op == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15 &&
        im % 4 == 0 && im >= 0 && im <= 124)
      return {1'b1, 3'b010, u[5:3], x[17:15], u[2], u[6], x[9:7], 2'b00};
    if (op == 103 && f3 == 0 && rd == 0 && im == 0 && rs1 != 0)
      return {1'b1, 4'b1000, x[19:15], 5'b0, 2'b10};
    if (x == 32'h0010_0073) return {1'b1, 16'h9002};
    return '0;
  endfunction

  function automatic logic [11:0] pick_imm();
    int t;
    t = $urandom_range(0, 9);
    case (t)
      0: return 12'(-33);
      1: return 12'(-32);
      2: return 12'(-1);
      3: return 12'd0;
      4: return 12'd31;
      5: return 12'd32;
      6: return 12'd124;
      7: return 12'd252;
      8: return 12'(4 * $urandom_range(0, 70));
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_reg(input logic [4:0] pref);
    int t;
    t = $urandom_range(0, 4);
    case (t)
      0: return 5'd0;
      1: return pref;
      2: return 5'd2;
      3: return 5'(8 + $urandom_range(0, 7));
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] im;
    logic [31:0] r;
    int k;
    rd = pick_reg(5'($urandom)); rs1 = pick_reg(rd); rs2 = pick_reg(5'd1);
    im = pick_imm();
    k = $urandom_range(0, 9);
    case (k)
      0, 1: return {im, rs1, 3'b000, rd, 7'b0010011};
      2:    return {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      3, 4: return {im, rs1, 3'b010, rd, 7'b0000011};
      5:    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
      6:    return {($urandom_range(0, 1) == 0) ? 12'd0 : 12'd4, rs1,
                    3'b000, ($urandom_range(0, 2) == 0) ? rd : 5'd0, 7'b1100111};
      7: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0013;
          1: return 32'h0010_0073;
          2: return 32'h1234_52B7;
          3: return {25'($urandom), 7'b1101111};
          default: return {25'($urandom), 7'b1100011};
        endcase
      end
      default: begin
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[1:0] = 2'b11;
        return r;
      end
    endcase
  endfunction

  // Reference model: halfwords in program order, completed words awaiting transfer
  logic [15:0] hq[$];
  logic [31:0] wq[$];
  logic [31:0] tq[$];
  int          xfer = 0;
  logic [31:0] m_tot = 0, m_comp = 0;
  logic        m_err = 0;

  always @(negedge clock) begin
    logic        e_ov, e_rdy, acc;
    logic [16:0] r;
    logic [15:0] lo, hi;
    if (!reset_n) begin
      hq.delete(); wq.delete(); tq.delete();
      xfer = 0; m_tot = 0; m_comp = 0; m_err = 0;
    end else begin
      e_ov  = (wq.size() != 0);
      e_rdy = (!e_ov || out_ready) && !flush;
      chk("in_ready", {31'b0, in_ready}, {31'b0, e_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      chk("idle", {31'b0, idle}, {31'b0, (hq.size() == 0) && !e_ov});
      chk("err", {31'b0, err}, {31'b0, m_err});
      chk("stat_total", stat_total, m_tot);
      chk("stat_comp", stat_comp, m_comp);
      if (e_ov) chk("out_word", out_word, wq[0]);
      if (e_ov && out_ready) begin
        void'(wq.pop_front());
        tq.push_back(out_word);
        xfer++;
      end
      acc = in_valid && e_rdy;
      if (acc) begin
        r = ref_c(in_inst);
        m_tot++;
        if (in_inst[1:0] != 2'b11) m_err = 1'b1;
        if (r[16]) begin
          m_comp++;
          hq.push_back(r[15:0]);
        end else begin
          hq.push_back(in_inst[15:0]);
          hq.push_back(in_inst[31:16]);
        end
      end else if (flush && (!e_ov || out_ready) && hq.size() == 1) begin
        hq.push_back(16'h0001);
      end
      while (hq.size() >= 2) begin
        lo = hq.pop_front();
        hi = hq.pop_front();
        wq.push_back({hi, lo});
      end
      if (wq.size() > 1) chk("word_overrun", wq.size(), 1);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; flush = 0; out_ready = 1; in_inst = '0;
    reset_n = 0;
    step(); step();
    reset_n = 1;
  endtask

  task automatic send(input logic [31:0] x);
    int n;
    n = 0;
    in_valid = 1; in_inst = x;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    step();
    in_valid = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    int x0;
    reset_n = 0; in_valid = 0; flush = 0; out_ready = 1; in_inst = '0;
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_idle", {31'b0, idle}, 1);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_total", stat_total, 0);
    do_reset();

    // c.addi followed by c.nop packs into one word
    send(32'h0055_0513);
    send(32'h0000_0013);
    chk("t1_total", stat_total, 2);
    chk("t1_comp", stat_comp, 2);
    step();
    chk("t1_nwords", tq.size(), 1);
    if (tq.size() >= 1) chk("t1_word", tq[0], 32'h0001_0515);
    chk("t1_idle", {31'b0, idle}, 1);

    // Uncompressible lui passes through one cycle after accept
    do_reset();
    send(32'h1234_52B7);
    chk("t2_valid", {31'b0, out_valid}, 1);
    chk("t2_word", out_word, 32'h1234_52B7);
    chk("t2_comp", stat_comp, 0);

    // Straddling 32-bit instruction, then flush pads with c.nop
    do_reset();
    send(32'h0055_0513);
    send(32'h1234_52B7);
    do_flush();
    step();
    chk("t3_nwords", tq.size(), 2);
    if (tq.size() >= 2) begin
      chk("t3_word0", tq[0], 32'h52B7_0515);
      chk("t3_word1", tq[1], 32'h0001_1234);
    end
    chk("t3_idle", {31'b0, idle}, 1);

    // c.mv + c.lwsp
    do_reset();
    send(32'h00B0_0533);
    send(32'h0081_2503);
    step();
    if (tq.size() >= 1) chk("t4_word", tq[0], 32'h4522_852E);
    else chk("t4_nwords", tq.size(), 1);

    // Backpressure holds the word and blocks input
    do_reset();
    out_ready = 0;
    send(32'h1234_52B7);
    in_valid = 1; in_inst = 32'h0055_0513;
    for (int i = 0; i < 5; i++) begin
      chk("t5_in_ready", {31'b0, in_ready}, 0);
      chk("t5_word_hold", out_word, 32'h1234_52B7);
      step();
    end
    in_valid = 0;
    x0 = xfer;
    out_ready = 1;
    step();
    out_ready = 0;
    step(); step();
    chk("t5_one_xfer", xfer - x0, 1);
    chk("t5_valid_after", {31'b0, out_valid}, 0);
    out_ready = 1;

    // Bad low bits set err; async reset mid-cycle drops the pending half
    do_reset();
    send(32'h0000_0001);
    chk("t6_err", {31'b0, err}, 1);
    chk("t6_word", out_word, 32'h0000_0001);
    send(32'h0055_0513);
    chk("t6_pending", {31'b0, idle}, 0);
    #2;
    reset_n = 0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 0);
    chk("t6_rst_word", out_word, 0);
    chk("t6_rst_err", {31'b0, err}, 0);
    chk("t6_rst_total", stat_total, 0);
    chk("t6_rst_comp", stat_comp, 0);
    chk("t6_rst_idle", {31'b0, idle}, 1);
    step(); step();
    reset_n = 1;
    step(); step(); step();
    chk("t6_no_word", xfer, 0);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_inst   = gen_inst();
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 0; out_ready = 1;
    do_flush();
    step(); step();
    chk("drain_idle", {31'b0, idle}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_rvc_pack.md
# ysyx_24080006_rvc_pack

Streaming RVC compressor and packer; the encode direction of the IF-stage RV16 expander. It accepts 32-bit RV32 instructions one per handshake and replaces each compressible one with its 16-bit C-extension equivalent. It packs the resulting mixed 16/32-bit stream little-endian into 32-bit output words. It sits between the code-image producer (loader/DMA path) and instruction memory, so the compacted image decodes back to the same instruction sequence through the expander.

## Interface
Parameters:
- CNT_W, 32, width of statistics counters

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input instruction valid
- in_ready  out  1  block accepts input this cycle
- in_inst  in  32  RV32 instruction
- flush  in  1  drain pending halfword, padding with c.nop
- out_valid  out  1  out_word valid
- out_ready  in  1  consumer accepts out_word
- out_word  out  32  packed word; lower half is earlier in program order
- idle  out  1  no pending halfword and no pending output
- err  out  1  sticky: an input with in_inst[1:0] != 2'b11 was accepted
- stat_total  out  CNT_W  instructions accepted (wraps)
- stat_comp  out  CNT_W  instructions compressed (wraps)

## Operation
- Compress function C(in_inst) returns ok and c16, evaluated in priority order. Any instruction not matched passes through as 32 bits.
  - 0x00000013 -> c.nop 0x0001.
  - addi rd,rd,imm; rd!=0; imm!=0; imm in [-32,31] -> {3'b000,imm[5],rd,imm[4:0],2'b01}.
  - addi rd,x0,imm; rd!=0; imm in [-32,31] -> c.li {3'b010,imm[5],rd,imm[4:0],2'b01}.
  - add rd,x0,rs2; funct7=0; rd!=0; rs2!=0 -> c.mv {4'b1000,rd,rs2,2'b10}.
  - add rd,rd,rs2; funct7=0; rd!=0; rs2!=0 -> c.add {4'b1001,rd,rs2,2'b10}.
  - lw rd,off(x2); rd!=0; off[1:0]=0; 0<=off<=252 -> c.lwsp {3'b010,off[5],rd,off[4:2],off[7:6],2'b10}.
  - sw rs2,off(x2); off[1:0]=0; 0<=off<=252 -> c.swsp {3'b110,off[5:2],off[7:6],rs2,2'b10}.
  - lw rd,off(rs1) with rd,rs1 in x8..x15; off[1:0]=0; 0<=off<=124 -> c.lw {3'b010,off[5:3],rs1[2:0],off[2],off[6],rd[2:0],2'b00}.
  - jalr x0,0(rs1); rs1!=0 -> c.jr {4'b1000,rs1,5'b0,2'b10}.
  - 0x00100073 -> c.ebreak 0x9002.
- PC-relative forms (jal, branches, auipc) are never compressed, because packing moves addresses.
- Inputs with in_inst[1:0] != 2'b11 pass through uncompressed and set err. Only reset clears err.
- State: hold[15:0] and hold_v (pending lower half); output register out_word and out_valid.
- Output slot is free when !out_valid || out_ready.
- Accept (in_valid && in_ready) with hold_v=0:
  - ok: hold<=c16, hold_v<=1, no output.
  - !ok: out_word<=in_inst, out_valid<=1.
- Accept with hold_v=1:
  - ok: out_word<={c16,hold}, hold_v<=0.
  - !ok: out_word<={in_inst[15:0],hold}, hold<=in_inst[31:16], hold_v stays 1.
- Flush with a free slot and hold_v=1: out_word<={16'h0001,hold}, hold_v<=0. Flush with hold_v=0 is a no-op.
- Counters increment on every accept: stat_total +1; stat_comp +1 when ok.
- idle = !hold_v && !out_valid.

## Timing
- in_ready = (!out_valid || out_ready) && !flush. Flush blocks input in the same cycle and has priority.
- Completed word: out_valid rises the cycle after the completing accept or flush (1-cycle latency).
- out_valid and out_word hold stable while out_valid && !out_ready.
- When the slot is freed by out_ready and nothing is produced that cycle, out_valid<=0.
- Back-to-back: a word completed every cycle under continuous out_ready sustains full throughput.
- Reset (asynchronous, any time): hold_v=0, hold=0, out_valid=0, out_word=0, err=0, stat_*=0. A pending half is discarded.

## Test plan
- 0x00550513 then 0x00000013, out_ready=1 -> one word 0x00010515; stat_total=2, stat_comp=2; idle=1 afterwards.
- 0x123452B7 alone with hold empty -> out_word 0x123452B7 one cycle after accept; stat_comp=0.
- 0x00550513 then 0x123452B7, then flush -> words 0x52B70515 then 0x00011234; hold_v=0 after.
- 0x00B00533 then 0x00812503 -> out_word 0x4522852E (c.mv a0,a1; c.lwsp a0,8(sp)).
- Backpressure: out_ready=0 while out_valid=1 -> in_ready=0, out_word unchanged for 5 cycles; release -> exactly one transfer.
- Accept 0x00000001 -> err=1, passthrough word 0x00000001; assert reset_n=0 with hold_v=1 -> all outputs zero immediately, no word emitted.
